// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Pixel-clock divider, H/V scan counters and sync/blank decode.
//            VGA_FRAME_CNT_EN builds an 8-bit frame counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int N         = 15,
  parameter int DIV       = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [N:0] horiz_count,
  output logic [N:0] vert_count,
  output logic       v_enable,
  output logic       horiz_sync,
  output logic       vert_sync,
  output logic       vga_blank,
  output logic       vga_sync,
  output logic       clkVGA,
  output logic       pix_tick,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int c_cw    = N + 1;
  localparam int c_div_w = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(DIV - 1);
  localparam logic [c_div_w-1:0] c_div_half = c_div_w'(DIV / 2);

  localparam logic [N:0] c_h_last  = c_cw'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [N:0] c_v_last  = c_cw'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [N:0] c_h_vis   = c_cw'(H_VISIBLE);
  localparam logic [N:0] c_v_vis   = c_cw'(V_VISIBLE);
  localparam logic [N:0] c_hs_beg  = c_cw'(H_VISIBLE + H_FRONT);
  localparam logic [N:0] c_hs_end  = c_cw'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [N:0] c_vs_beg  = c_cw'(V_VISIBLE + V_FRONT);
  localparam logic [N:0] c_vs_end  = c_cw'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [c_div_w-1:0] r_div_cnt;
  logic [c_div_w-1:0] w_div_next;
  logic [N:0]         r_h;
  logic [N:0]         r_v;
  logic [N:0]         w_h_next;
  logic [N:0]         w_v_next;
  logic               w_adv;
  logic               w_wrap;
  logic               w_vis;
  logic               w_hs_n;
  logic               w_vs_n;

  logic r_v_enable;
  logic r_hs_n;
  logic r_vs_n;
  logic r_clk_vga;
  logic r_pix_tick;
  logic r_frame_start;

  // Next-state counters: a pixel advances on the edge closing the last divider phase.
  always_comb begin
    w_adv      = enable && (r_div_cnt == c_div_last);
    w_div_next = r_div_cnt;
    w_h_next   = r_h;
    w_v_next   = r_v;
    w_wrap     = 1'b0;
    if (enable) begin
      w_div_next = (r_div_cnt == c_div_last) ? '0 : r_div_cnt + 1'b1;
    end
    if (w_adv) begin
      if (r_h == c_h_last) begin
        w_h_next = '0;
        if (r_v == c_v_last) begin
          w_v_next = '0;
          w_wrap   = 1'b1;
        end else begin
          w_v_next = r_v + 1'b1;
        end
      end else begin
        w_h_next = r_h + 1'b1;
      end
    end
  end

  // Decode from next-state counts so registered outputs line up with the counts.
  always_comb begin
    w_vis  = (w_h_next < c_h_vis) && (w_v_next < c_v_vis);
    w_hs_n = !((w_h_next >= c_hs_beg) && (w_h_next < c_hs_end));
    w_vs_n = !((w_v_next >= c_vs_beg) && (w_v_next < c_vs_end));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt     <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_v_enable    <= 1'b0;
      r_hs_n        <= 1'b1;
      r_vs_n        <= 1'b1;
      r_clk_vga     <= 1'b0;
      r_pix_tick    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div_cnt     <= w_div_next;
      r_h           <= w_h_next;
      r_v           <= w_v_next;
      r_pix_tick    <= w_adv;
      r_frame_start <= w_wrap;
      if (enable) begin
        r_v_enable <= w_vis;
        r_hs_n     <= w_hs_n;
        r_vs_n     <= w_vs_n;
        r_clk_vga  <= (w_div_next >= c_div_half);
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] r_frame_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_count <= 8'd0;
    end else if (w_wrap) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = 8'd0;
`endif

  assign horiz_count = r_h;
  assign vert_count  = r_v;
  assign v_enable    = r_v_enable;
  assign vga_blank   = r_v_enable;
  assign vga_sync    = 1'b0;
  assign horiz_sync  = r_hs_n;
  assign vert_sync   = r_vs_n;
  assign clkVGA      = r_clk_vga;
  assign pix_tick    = r_pix_tick;
  assign frame_start = r_frame_start;

endmodule

`default_nettype wire
